// File: rtl/core_pkg.sv
// Shared definitions for the platform-to-core write RAM: write FSM states and AXI encodings.
package core_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/waxi_dpram_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the platform master and the RAM slave.
// Handshake: a transfer happens on a rising clock edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that edge, and ready may depend on valid.
interface waxi_dpram_if #(
  parameter int IdWidth   = 8,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [IdWidth-1:0]     awid;
  logic [AddrWidth-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic [1:0]             awlock;
  logic [3:0]             awcache;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;

  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [IdWidth-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dpram.sv
// Generic single-clock true dual-port RAM with byte-enable writes and read-first behaviour.
module dpram #(
  parameter int ByteLength = 8,
  parameter int DataWidth  = 32,
  parameter int Depth      = 512,
  localparam int AddrBits  = $clog2(Depth),
  localparam int NumBytes  = DataWidth / ByteLength
) (
  input  logic                 clk,
  input  logic [AddrBits-1:0]  a_addr,
  input  logic                 a_wren,
  input  logic [NumBytes-1:0]  a_wstrb,
  input  logic [DataWidth-1:0] a_wdata,
  input  logic                 a_rden,
  output logic [DataWidth-1:0] a_rdata,
  input  logic [AddrBits-1:0]  b_addr,
  input  logic                 b_wren,
  input  logic [NumBytes-1:0]  b_wstrb,
  input  logic [DataWidth-1:0] b_wdata,
  input  logic                 b_rden,
`ifdef SIM
  output logic [DataWidth-1:0] mem_o [Depth],
`endif
  output logic [DataWidth-1:0] b_rdata
);

  logic [DataWidth-1:0] mem [Depth];

  // Reads sample the array before this edge's writes land, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (a_rden) a_rdata <= mem[a_addr];
    if (b_rden) b_rdata <= mem[b_addr];
    for (int i = 0; i < NumBytes; i++) begin
      if (a_wren && a_wstrb[i]) mem[a_addr][i*ByteLength +: ByteLength] <= a_wdata[i*ByteLength +: ByteLength];
      if (b_wren && b_wstrb[i]) mem[b_addr][i*ByteLength +: ByteLength] <= b_wdata[i*ByteLength +: ByteLength];
    end
  end

`ifdef SIM
  assign mem_o = mem;
`endif

endmodule

// File: rtl/waxi_dpram.sv
// Platform-to-core RAM: AXI4 write-only slave on one port, synchronous core read on the other.
module waxi_dpram
  import core_pkg::*;
#(
  parameter int ByteLength  = 8,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int Size        = 2048,
  parameter int IdWidth     = 8,
  localparam int Depth      = Size / (DataWidth / ByteLength)
) (
  input  logic                 axi_clk_i,
  input  logic                 rstn_i,
`ifdef SIM
  output logic [DataWidth-1:0] mem_o [Depth],
`endif
  input  logic [AddrWidth-1:0] core_m_addr_i,
  input  logic                 core_m_rden_i,
  output logic [DataWidth-1:0] core_m_rdata_o,
  output logic                 core_m_hit_o,
  output wr_state_e            dbg_state_o,
  waxi_dpram_if.slave          s_axi
);

  localparam int UsedAddrWidth   = $clog2(Depth);
  localparam int AddrOffsetWidth = $clog2(DataWidth / ByteLength);
  localparam int LocalAddrWidth  = UsedAddrWidth + AddrOffsetWidth;
  localparam logic [2:0] FullSize = 3'($clog2(DataWidth / 8));

  if (DataWidth % ByteLength != 0) begin : g_bad_width
    $error("waxi_dpram: DataWidth must be a multiple of ByteLength");
  end
  if ((Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("waxi_dpram: Depth must be a power of two");
  end

  wr_state_e                 state;
  logic [IdWidth-1:0]        id_q;
  logic [LocalAddrWidth-1:0] addr_q;
  logic [7:0]                cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      bvalid_q;
  logic [IdWidth-1:0]        bid_q;
  logic [1:0]                bresp_q;

  logic awready;
  logic wready;
  logic beat;
  logic last_beat;
  logic len_err;

  // Ready lines are held low while reset is asserted so nothing handshakes in a reset cycle.
  assign awready   = rstn_i && (state == WR_IDLE);
  assign wready    = rstn_i && (state == WR_DATA);
  assign beat      = wready && s_axi.wvalid;
  assign last_beat = s_axi.wlast || (cnt_q == 8'd0);
  assign len_err   = s_axi.wlast != (cnt_q == 8'd0);

  always_ff @(posedge axi_clk_i) begin
    if (!rstn_i) begin
      state    <= WR_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= AXI_BURST_FIXED;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= AXI_RESP_OKAY;
    end else begin
      case (state)
        WR_IDLE: begin
          if (s_axi.awvalid) begin
            id_q    <= s_axi.awid;
            addr_q  <= s_axi.awaddr[LocalAddrWidth-1:0];
            cnt_q   <= s_axi.awlen;
            size_q  <= s_axi.awsize;
            burst_q <= s_axi.awburst;
            err_q   <= (s_axi.awsize != FullSize);
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (beat) begin
            // The address register is exactly RAM-sized, so increments wrap modulo Size.
            if (burst_q != AXI_BURST_FIXED) addr_q <= addr_q + (LocalAddrWidth'(1) << size_q);
            cnt_q <= cnt_q - 8'd1;
            if (last_beat) begin
              err_q    <= err_q || len_err;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || len_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              state    <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            state    <= WR_IDLE;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign dbg_state_o   = state;
  assign core_m_hit_o  = core_m_rden_i;

  logic [DataWidth-1:0] unused_a_rdata;
  logic                 unused_bits;
  assign unused_bits = ^{core_m_addr_i[AddrWidth-1:LocalAddrWidth], core_m_addr_i[AddrOffsetWidth-1:0],
                         s_axi.awaddr[AddrWidth-1:LocalAddrWidth], s_axi.awlock, s_axi.awcache,
                         s_axi.awprot, unused_a_rdata};

  dpram #(
    .ByteLength (ByteLength),
    .DataWidth  (DataWidth),
    .Depth      (Depth)
  ) u_ram (
    .clk     (axi_clk_i),
    .a_addr  (addr_q[LocalAddrWidth-1:AddrOffsetWidth]),
    .a_wren  (beat && !err_q),
    .a_wstrb (s_axi.wstrb),
    .a_wdata (s_axi.wdata),
    .a_rden  (1'b0),
    .a_rdata (unused_a_rdata),
    .b_addr  (core_m_addr_i[LocalAddrWidth-1:AddrOffsetWidth]),
    .b_wren  (1'b0),
    .b_wstrb ('0),
    .b_wdata ('0),
    .b_rden  (core_m_rden_i),
`ifdef SIM
    .mem_o   (mem_o),
`endif
    .b_rdata (core_m_rdata_o)
  );

endmodule

// File: tb/tb_waxi_dpram.sv
// Directed bench for waxi_dpram: AXI write bursts, strobes, errors, backpressure, collision, reset.
module tb_waxi_dpram;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_rden = 1'b0;
  logic [31:0] core_rdata;
  logic        core_hit;
  wr_state_e   dbg_state;
  int          n_total = 0;
  int          n_bad = 0;
`ifdef SIM
  logic [31:0] mem [512];
`endif

  waxi_dpram_if #(.IdWidth(8), .AddrWidth(32), .DataWidth(32)) axi ();

  waxi_dpram dut (
    .axi_clk_i      (clk),
    .rstn_i         (rstn),
`ifdef SIM
    .mem_o          (mem),
`endif
    .core_m_addr_i  (core_addr),
    .core_m_rden_i  (core_rden),
    .core_m_rdata_o (core_rdata),
    .core_m_hit_o   (core_hit),
    .dbg_state_o    (dbg_state),
    .s_axi          (axi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    while (!axi.awready && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq("aw_timeout", 64'd0, 64'd1);
    tick();
    axi.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
    while (!axi.wready && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq("w_timeout", 64'd0, 64'd1);
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic b_wait(input string tag, input logic [7:0] id, input logic [1:0] resp);
    int n = 0;
    axi.bready = 1'b1;
    while (!axi.bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq({tag, "_b_timeout"}, 64'd0, 64'd1);
    check_eq({tag, "_bid"}, 64'(axi.bid), 64'(id));
    check_eq({tag, "_bresp"}, 64'(axi.bresp), 64'(resp));
    tick();
    axi.bready = 1'b0;
    check_eq({tag, "_bvalid_low"}, 64'(axi.bvalid), 64'd0);
    check_eq({tag, "_idle"}, 64'(dbg_state), 64'(WR_IDLE));
  endtask

  task automatic core_read(input logic [31:0] addr, output logic [31:0] data);
    core_addr = addr; core_rden = 1'b1;
    #1 check_eq("hit", 64'(core_hit), 64'd1);
    tick();
    core_rden = 1'b0;
    data = core_rdata;
  endtask

  task automatic write1(input logic [7:0] id, input logic [31:0] addr, input logic [31:0] data);
    aw_send(id, addr, 8'd0, 3'd2, AXI_BURST_INCR);
    w_beat(data, 4'hF, 1'b1);
    b_wait("pre", id, AXI_RESP_OKAY);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    core_read(addr, d);
    check_eq(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    logic [31:0] d;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;

    // Reset values
    repeat (3) tick();
    check_eq("rst_awready", 64'(axi.awready), 64'd0);
    check_eq("rst_wready", 64'(axi.wready), 64'd0);
    check_eq("rst_bvalid", 64'(axi.bvalid), 64'd0);
    check_eq("rst_bid", 64'(axi.bid), 64'd0);
    check_eq("rst_bresp", 64'(axi.bresp), 64'd0);
    rstn = 1'b1;
    #1 check_eq("idle_awready", 64'(axi.awready), 64'd1);
    tick();

    // Single beat
    aw_send(8'h5A, 32'h10, 8'd0, 3'd2, AXI_BURST_INCR);
    check_eq("single_wready", 64'(axi.wready), 64'd1);
    check_eq("single_awready_low", 64'(axi.awready), 64'd0);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    b_wait("single", 8'h5A, AXI_RESP_OKAY);
    expect_word("single_rd", 32'h10, 32'hDEADBEEF);
    expect_word("high_bits_ignored", 32'h0000_0810, 32'hDEADBEEF);
    core_addr = 32'h20; tick();
    check_eq("rdata_hold", 64'(core_rdata), 64'hDEADBEEF);

    // INCR burst
    aw_send(8'h03, 32'h20, 8'd3, 3'd2, AXI_BURST_INCR);
    for (int i = 1; i <= 4; i++) w_beat(32'(i), 4'hF, i == 4);
    b_wait("incr", 8'h03, AXI_RESP_OKAY);
    for (int i = 0; i < 4; i++) expect_word("incr_rd", 32'h20 + 32'(4 * i), 32'(i + 1));

    // FIXED burst
    write1(8'h01, 32'h44, 32'h44444444);
    aw_send(8'h04, 32'h40, 8'd3, 3'd2, AXI_BURST_FIXED);
    for (int i = 1; i <= 4; i++) w_beat(32'(i), 4'hF, i == 4);
    b_wait("fixed", 8'h04, AXI_RESP_OKAY);
    expect_word("fixed_40", 32'h40, 32'd4);
    expect_word("fixed_44", 32'h44, 32'h44444444);

    // WRAP handled as INCR, and address wrap at the top of the RAM
    aw_send(8'h06, 32'h240, 8'd1, 3'd2, AXI_BURST_WRAP);
    w_beat(32'hA0A0A0A0, 4'hF, 1'b0);
    w_beat(32'hA1A1A1A1, 4'hF, 1'b1);
    b_wait("wrap", 8'h06, AXI_RESP_OKAY);
    expect_word("wrap_240", 32'h240, 32'hA0A0A0A0);
    expect_word("wrap_244", 32'h244, 32'hA1A1A1A1);
    aw_send(8'h07, 32'h7FC, 8'd1, 3'd2, AXI_BURST_INCR);
    w_beat(32'h7F7F7F7F, 4'hF, 1'b0);
    w_beat(32'h00C0FFEE, 4'hF, 1'b1);
    b_wait("top", 8'h07, AXI_RESP_OKAY);
    expect_word("top_7fc", 32'h7FC, 32'h7F7F7F7F);
    expect_word("top_wrap_0", 32'h0, 32'h00C0FFEE);

    // Byte strobes
    write1(8'h02, 32'h80, 32'h11223344);
    aw_send(8'h08, 32'h80, 8'd0, 3'd2, AXI_BURST_INCR);
    w_beat(32'hAABBCCDD, 4'b0101, 1'b1);
    b_wait("strb", 8'h08, AXI_RESP_OKAY);
    expect_word("strb_rd", 32'h80, 32'h11BB33DD);

    // Early wlast, missing wlast, bad size
    aw_send(8'h09, 32'hA0, 8'd1, 3'd2, AXI_BURST_INCR);
    w_beat(32'h00000055, 4'hF, 1'b1);
    b_wait("early_last", 8'h09, AXI_RESP_SLVERR);
    expect_word("early_last_rd", 32'hA0, 32'h55);
    aw_send(8'h0A, 32'hB0, 8'd0, 3'd2, AXI_BURST_INCR);
    w_beat(32'h00000066, 4'hF, 1'b0);
    b_wait("no_last", 8'h0A, AXI_RESP_SLVERR);
    write1(8'h0B, 32'hC0, 32'hCAFEF00D);
    aw_send(8'h0C, 32'hC0, 8'd0, 3'd1, AXI_BURST_INCR);
    w_beat(32'h12345678, 4'hF, 1'b1);
    b_wait("bad_size", 8'h0C, AXI_RESP_SLVERR);
    expect_word("bad_size_rd", 32'hC0, 32'hCAFEF00D);
    aw_send(8'h0D, 32'hD0, 8'd0, 3'd2, AXI_BURST_INCR);
    w_beat(32'h0000D0D0, 4'hF, 1'b1);
    b_wait("after_err", 8'h0D, AXI_RESP_OKAY);

    // B backpressure
    aw_send(8'h77, 32'hE0, 8'd0, 3'd2, AXI_BURST_INCR);
    w_beat(32'h0000E0E0, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_bvalid", 64'(axi.bvalid), 64'd1);
      check_eq("bp_bid", 64'(axi.bid), 64'h77);
      check_eq("bp_bresp", 64'(axi.bresp), 64'd0);
      check_eq("bp_awready", 64'(axi.awready), 64'd0);
      tick();
    end
    b_wait("bp", 8'h77, AXI_RESP_OKAY);

    // Same-address collision
    write1(8'h10, 32'h100, 32'h0000AAAA);
    aw_send(8'h11, 32'h100, 8'd0, 3'd2, AXI_BURST_INCR);
    axi.wdata = 32'h0000BBBB; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
    core_addr = 32'h100; core_rden = 1'b1;
    check_eq("coll_wready", 64'(axi.wready), 64'd1);
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0; core_rden = 1'b0;
    check_eq("coll_old", 64'(core_rdata), 64'h0000AAAA);
    expect_word("coll_new", 32'h100, 32'h0000BBBB);
    b_wait("coll", 8'h11, AXI_RESP_OKAY);

    // Reset mid-burst
    aw_send(8'h99, 32'h200, 8'd3, 3'd2, AXI_BURST_INCR);
    w_beat(32'h000000B0, 4'hF, 1'b0);
    w_beat(32'h000000B1, 4'hF, 1'b0);
    rstn = 1'b0;
    tick();
    check_eq("mid_rst_awready", 64'(axi.awready), 64'd0);
    check_eq("mid_rst_wready", 64'(axi.wready), 64'd0);
    check_eq("mid_rst_bvalid", 64'(axi.bvalid), 64'd0);
    check_eq("mid_rst_bid", 64'(axi.bid), 64'd0);
    check_eq("mid_rst_bresp", 64'(axi.bresp), 64'd0);
    check_eq("mid_rst_state", 64'(dbg_state), 64'(WR_IDLE));
    rstn = 1'b1;
    tick();
    check_eq("post_rst_bvalid", 64'(axi.bvalid), 64'd0);
    expect_word("rst_beat0", 32'h200, 32'hB0);
    expect_word("rst_beat1", 32'h204, 32'hB1);
    aw_send(8'h42, 32'h300, 8'd0, 3'd2, AXI_BURST_INCR);
    w_beat(32'h0BADF00D, 4'hF, 1'b1);
    b_wait("post_rst", 8'h42, AXI_RESP_OKAY);
    expect_word("post_rst_rd", 32'h300, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
